// File: rtl/vcfg_unit.sv
// Vector configuration unit: executes VSETVLI/VSETIVLI/VSETVL, holding architectural vl/vtype/vstart.
// Define VCFG_FRAC_LMUL_EN to accept fractional LMUL (mf8/mf4/mf2); otherwise those encodings set vill.
module vcfg_unit #(
    parameter int XLEN    = 32,
    parameter int VLEN    = 512,
    parameter int ELEN    = 32,
    parameter int VL_BITS = $clog2(VLEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic               req_rs1_zero,
    input  logic               req_rd_zero,
    input  logic [4:0]         req_uimm,
    input  logic [10:0]        req_zimm,
    input  logic [XLEN-1:0]    req_rs1,
    input  logic [XLEN-1:0]    req_rs2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [XLEN-1:0]    resp_vl,
    output logic [VL_BITS-1:0] vl,
    output logic [XLEN-1:0]    vtype,
    output logic [VL_BITS-1:0] vstart
);

    localparam int              SEW_MAX_LOG = $clog2(ELEN / 8);
    localparam logic [XLEN-1:0] VLEN_X      = XLEN'(VLEN);
    localparam logic [XLEN-1:0] VILL_VTYPE  = {1'b1, {(XLEN-1){1'b0}}};
`ifdef VCFG_FRAC_LMUL_EN
    localparam int              ELEN_LOG    = $clog2(ELEN);
`endif

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t state, state_next;
    logic   accept;

    logic [1:0]      op_p0;
    logic            rs1_zero_p0;
    logic            rd_zero_p0;
    logic [4:0]      uimm_p0;
    logic [10:0]     zimm_p0;
    logic [XLEN-1:0] rs1_p0;
    logic [XLEN-1:0] rs2_p0;

    logic [XLEN-1:0] vtype_raw_p1;
    logic [2:0]      vsew_p1;
    logic [2:0]      vlmul_p1;
    logic            illegal_p1;
    logic [XLEN-1:0] vlmax_p1;
    logic [XLEN-1:0] avl_p1;
    logic [XLEN-1:0] vl_new_p1;
    logic [XLEN-1:0] vtype_new_p1;
`ifdef VCFG_FRAC_LMUL_EN
    logic [4:0]      frac_shift_p1;
`endif

    function automatic logic [XLEN-1:0] clamp_vl(input logic [XLEN-1:0] avl_in,
                                                 input logic [XLEN-1:0] vlmax_in);
        return (avl_in > vlmax_in) ? vlmax_in : avl_in;
    endfunction

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = CALC;
                end
            end
            CALC: state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req_valid & req_ready;

    // Stage p0: request capture (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0       <= req_op;
            rs1_zero_p0 <= req_rs1_zero;
            rd_zero_p0  <= req_rd_zero;
            uimm_p0     <= req_uimm;
            zimm_p0     <= req_zimm;
            rs1_p0      <= req_rs1;
            rs2_p0      <= req_rs2;
        end
    end

    // Stage p1: vtype decode, legality, VLMAX and AVL selection
    always_comb begin
        case (op_p0)
            2'b00:   vtype_raw_p1 = {{(XLEN-11){1'b0}}, zimm_p0};
            2'b01:   vtype_raw_p1 = {{(XLEN-10){1'b0}}, zimm_p0[9:0]};
            default: vtype_raw_p1 = rs2_p0;
        endcase
    end

    assign vsew_p1  = vtype_raw_p1[5:3];
    assign vlmul_p1 = vtype_raw_p1[2:0];

    always_comb begin
        illegal_p1 = 1'b0;
        vlmax_p1   = '0;
`ifdef VCFG_FRAC_LMUL_EN
        frac_shift_p1 = {2'b00, vsew_p1} + 5'd3 + (5'd8 - {2'b00, vlmul_p1});
`endif
        if (vtype_raw_p1[XLEN-1]) illegal_p1 = 1'b1;
        if (|vtype_raw_p1[XLEN-2:8]) illegal_p1 = 1'b1;
        if (int'(vsew_p1) > SEW_MAX_LOG) illegal_p1 = 1'b1;
        if (op_p0 == 2'b11) illegal_p1 = 1'b1;
        if (vlmul_p1 == 3'b100) illegal_p1 = 1'b1;

        if (!vlmul_p1[2]) begin
            vlmax_p1 = (VLEN_X >> ({2'b00, vsew_p1} + 5'd3)) << vlmul_p1;
        end else if (vlmul_p1 != 3'b100) begin
`ifdef VCFG_FRAC_LMUL_EN
            // SEW <= ELEN*LMUL is equivalent to log2(SEW) + log2(1/LMUL) <= log2(ELEN)
            if (int'(frac_shift_p1) > ELEN_LOG) illegal_p1 = 1'b1;
            vlmax_p1 = VLEN_X >> frac_shift_p1;
`else
            illegal_p1 = 1'b1;
`endif
        end
    end

    // rs1=x0 with rd=x0 keeps the current vl, clamped below to the new VLMAX
    always_comb begin
        if (op_p0 == 2'b01) begin
            avl_p1 = {{(XLEN-5){1'b0}}, uimm_p0};
        end else if (!rs1_zero_p0) begin
            avl_p1 = rs1_p0;
        end else if (!rd_zero_p0) begin
            avl_p1 = vlmax_p1;
        end else begin
            avl_p1 = {{(XLEN-VL_BITS){1'b0}}, vl};
        end
    end

    assign vl_new_p1    = illegal_p1 ? '0 : clamp_vl(avl_p1, vlmax_p1);
    assign vtype_new_p1 = illegal_p1 ? VILL_VTYPE : vtype_raw_p1;

    // Stage p2: architectural state commit on the CALC->RESP edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vl      <= '0;
            vtype   <= VILL_VTYPE;
            vstart  <= '0;
            resp_vl <= '0;
        end else if (state == CALC) begin
            vl      <= vl_new_p1[VL_BITS-1:0];
            vtype   <= vtype_new_p1;
            vstart  <= '0;
            resp_vl <= vl_new_p1;
        end
    end

endmodule
